// File: rtl/axi_shift_sequencer_pkg.sv
// Shared types and constants for the AXI-Lite shift-register sequencer:
// FSM state encoding, slave register map and control-word bit positions.
package axi_shift_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WRESP,
    READ,
    RRESP,
    DONE
  } state_t;

  localparam logic [31:0] CTRL_OFFSET = 32'h0000_0000;
  localparam logic [31:0] DATA_OFFSET = 32'h0000_0004;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_DIN = 1;
  localparam int CTRL_DIR = 2;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // One shift request: enable strobe plus the bit and direction to shift.
  function automatic logic [31:0] ctrl_word(input logic dir, input logic din);
    logic [31:0] w;
    w           = '0;
    w[CTRL_EN]  = 1'b1;
    w[CTRL_DIN] = din;
    w[CTRL_DIR] = dir;
    return w;
  endfunction

endpackage

// File: rtl/axi_shift_sequencer.sv
// AXI4-Lite master that shifts a command pattern into a remote shift register,
// one control write per bit, then reads the register back as the result.
module axi_shift_sequencer
  import axi_shift_sequencer_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int unsigned MAX_LEN   = 32
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_pattern,
  input  logic [5:0]  cmd_len,
  input  logic        cmd_dir,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_err,
  output logic [31:0] m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [31:0] m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);

  localparam logic [5:0] LEN_LIMIT = 6'(MAX_LEN);

  state_t      state, state_nxt;
  logic        out_en;
  logic        aw_done, w_done;
  logic [31:0] pattern;
  logic [5:0]  len, bit_cnt;
  logic        dir;
  logic        aw_hs, w_hs;
  logic        cmd_accept;
  logic [4:0]  bit_idx;
  logic        din;

  assign aw_hs      = m_axi_awvalid & m_axi_awready;
  assign w_hs       = m_axi_wvalid & m_axi_wready;
  assign cmd_accept = (state == IDLE) & out_en & cmd_valid;

  // Left shifts send the MSB of the window first, right shifts the LSB first.
  assign bit_idx = dir ? bit_cnt[4:0] : 5'(len - bit_cnt - 6'd1);
  assign din     = pattern[bit_idx];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    cmd_ready     = 1'b0;
    res_valid     = 1'b0;
    m_axi_awaddr  = '0;
    m_axi_awvalid = 1'b0;
    m_axi_wdata   = '0;
    m_axi_wstrb   = '0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_araddr  = '0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = out_en;
        if (cmd_accept) state_nxt = (cmd_len == 6'd0) ? READ : WRITE;
      end
      WRITE: begin
        m_axi_awaddr  = ADDR_BASE + CTRL_OFFSET;
        m_axi_awvalid = ~aw_done;
        m_axi_wdata   = ctrl_word(dir, din);
        m_axi_wstrb   = 4'hF;
        m_axi_wvalid  = ~w_done;
        if ((aw_done | aw_hs) && (w_done | w_hs)) state_nxt = WRESP;
      end
      WRESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          if (m_axi_bresp != RESP_OKAY)       state_nxt = READ;
          else if ((bit_cnt + 6'd1) < len)    state_nxt = WRITE;
          else                                state_nxt = READ;
        end
      end
      READ: begin
        m_axi_araddr  = ADDR_BASE + DATA_OFFSET;
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_nxt = RRESP;
      end
      RRESP: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid) state_nxt = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // out_en keeps cmd_ready low while reset is asserted even though state is IDLE.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_en   <= 1'b0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      pattern  <= '0;
      len      <= '0;
      dir      <= 1'b0;
      bit_cnt  <= '0;
      res_data <= '0;
      res_err  <= 1'b0;
    end else begin
      out_en <= 1'b1;
      if (cmd_accept) begin
        pattern <= cmd_pattern;
        len     <= (cmd_len > LEN_LIMIT) ? LEN_LIMIT : cmd_len;
        dir     <= cmd_dir;
        bit_cnt <= '0;
        res_err <= 1'b0;
      end
      if (state == WRITE) begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end else begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (state == WRESP && m_axi_bvalid) begin
        bit_cnt <= bit_cnt + 6'd1;
        if (m_axi_bresp != RESP_OKAY) res_err <= 1'b1;
      end
      if (state == RRESP && m_axi_rvalid) begin
        res_data <= m_axi_rdata;
        if (m_axi_rresp != RESP_OKAY) res_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_shift_sequencer.sv
// Bench for axi_shift_sequencer: AXI-Lite slave with a 4-bit shift register,
// a transaction-level expectation model and a per-cycle output checker.
module tb_axi_shift_sequencer;

  localparam logic [31:0] BASE = 32'h4000_1000;
  localparam int          MAXL = 32;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_pattern = '0;
  logic [5:0]  cmd_len = '0;
  logic        cmd_dir = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic        res_err;
  logic [31:0] m_axi_awaddr;
  logic        m_axi_awvalid;
  logic        m_axi_awready = 1'b0;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid;
  logic        m_axi_wready = 1'b0;
  logic [1:0]  m_axi_bresp = 2'b00;
  logic        m_axi_bvalid = 1'b0;
  logic        m_axi_bready;
  logic [31:0] m_axi_araddr;
  logic        m_axi_arvalid;
  logic        m_axi_arready = 1'b0;
  logic [31:0] m_axi_rdata = '0;
  logic [1:0]  m_axi_rresp = 2'b00;
  logic        m_axi_rvalid = 1'b0;
  logic        m_axi_rready;

  always #5 aclk = ~aclk;

  axi_shift_sequencer #(.ADDR_BASE(BASE), .MAX_LEN(MAXL)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_pattern(cmd_pattern),
    .cmd_len(cmd_len), .cmd_dir(cmd_dir),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=%0b required=%0b at %0t", name, act, req, $time);
    end
  endtask

  // Slave configuration and state
  int          aw_delay = 0, w_delay = 0, b_delay = 0, err_on = 0;
  int          aw_wait = 0, w_wait = 0, b_wait = 0, wr_count = 0, rd_count = 0;
  bit          aw_got, w_got, aw_fire, w_fire, b_fire, ar_got, ar_fire, r_fire;
  logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
  logic [3:0]  sreg = '0;
  logic [31:0] wr_log[$];

  // Expectation model state
  int          phase = 0;       // 0 idle, 1 busy, 2 result presented
  bit          seen = 0;
  logic [31:0] exp_data = '0;
  logic        exp_err = 1'b0;
  logic [3:0]  exp_reg = '0;
  bit          prev_aw_hs, prev_aw_wait, prev_w_hs, prev_w_wait, prev_awv, prev_wv;
  logic [31:0] prev_awaddr, prev_wdata;

  task automatic slave_step();
    logic [1:0] br;
    if (!aresetn) begin
      m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_arready = 0; m_axi_rvalid = 0;
      aw_got = 0; w_got = 0; aw_fire = 0; w_fire = 0; b_fire = 0; ar_got = 0; ar_fire = 0; r_fire = 0;
      aw_wait = 0; w_wait = 0; b_wait = 0; sreg = '0;
      return;
    end
    // retire handshakes completed at the posedge just past
    if (aw_fire) begin m_axi_awready = 0; aw_fire = 0; end
    if (w_fire)  begin m_axi_wready = 0;  w_fire = 0;  end
    if (b_fire)  begin m_axi_bvalid = 0;  b_fire = 0;  end
    if (ar_fire) begin m_axi_arready = 0; ar_fire = 0; end
    if (r_fire)  begin m_axi_rvalid = 0;  r_fire = 0;  end
    if (aw_got && w_got && !m_axi_bvalid) begin
      if (b_wait >= b_delay) begin
        wr_count++;
        br = (wr_count == err_on) ? 2'b10 : 2'b00;
        wr_log.push_back(cap_wdata);
        if (br == 2'b00 && cap_awaddr == BASE && cap_wdata[0])
          sreg = cap_wdata[2] ? {cap_wdata[1], sreg[3:1]} : {sreg[2:0], cap_wdata[1]};
        m_axi_bresp = br; m_axi_bvalid = 1;
        aw_got = 0; w_got = 0; b_wait = 0;
      end else b_wait++;
    end
    if (m_axi_awvalid && !m_axi_awready && !aw_got) begin
      if (aw_wait >= aw_delay) begin
        m_axi_awready = 1; aw_fire = 1; aw_got = 1; cap_awaddr = m_axi_awaddr; aw_wait = 0;
      end else aw_wait++;
    end
    if (m_axi_wvalid && !m_axi_wready && !w_got) begin
      if (w_wait >= w_delay) begin
        m_axi_wready = 1; w_fire = 1; w_got = 1; cap_wdata = m_axi_wdata; w_wait = 0;
      end else w_wait++;
    end
    if (m_axi_bvalid && m_axi_bready && !b_fire) b_fire = 1;
    if (m_axi_arvalid && !m_axi_arready && !ar_got) begin
      m_axi_arready = 1; ar_fire = 1; ar_got = 1; cap_araddr = m_axi_araddr;
    end else if (ar_got && !ar_fire && !m_axi_rvalid) begin
      rd_count++;
      m_axi_rdata = (cap_araddr == BASE + 32'h4) ? {28'b0, sreg} : 32'hDEAD_BEEF;
      m_axi_rresp = 2'b00; m_axi_rvalid = 1; ar_got = 0;
    end
    if (m_axi_rvalid && m_axi_rready && !r_fire) r_fire = 1;
  endtask

  task automatic check_cycle();
    int nact;
    if (!aresetn) begin
      chk1("rst_cmd_ready", cmd_ready, 1'b0);
      chk("rst_valids", {26'b0, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                         m_axi_arvalid, m_axi_rready, res_valid}, 32'h0);
      chk("rst_addr_data", m_axi_awaddr | m_axi_araddr | m_axi_wdata | {28'b0, m_axi_wstrb}, 32'h0);
      chk("rst_result", res_data | {31'b0, res_err}, 32'h0);
      return;
    end
    chk1("cmd_ready", cmd_ready, (phase == 0) && seen);
    chk1("res_valid", res_valid, phase == 2);
    if (res_valid) begin
      chk("res_data", res_data, exp_data);
      chk1("res_err", res_err, exp_err);
    end
    nact = int'(m_axi_awvalid | m_axi_wvalid) + int'(m_axi_bready) + int'(m_axi_arvalid)
         + int'(m_axi_rready) + int'(res_valid) + int'(cmd_ready);
    chk1("one_in_flight", nact <= 1, 1'b1);
    if (prev_aw_hs) chk1("awvalid_drop", m_axi_awvalid, 1'b0);
    if (prev_aw_wait) begin
      chk1("awvalid_hold", m_axi_awvalid, 1'b1);
      chk("awaddr_stable", m_axi_awaddr, prev_awaddr);
    end
    if (prev_w_hs) chk1("wvalid_drop", m_axi_wvalid, 1'b0);
    if (prev_w_wait) begin
      chk1("wvalid_hold", m_axi_wvalid, 1'b1);
      chk("wdata_stable", m_axi_wdata, prev_wdata);
    end
    if (!prev_awv && !prev_wv && (m_axi_awvalid || m_axi_wvalid))
      chk("aw_w_together", {30'b0, m_axi_awvalid, m_axi_wvalid}, 32'h3);
    if (m_axi_awvalid) chk("awaddr", m_axi_awaddr, BASE);
    if (m_axi_wvalid)  chk("wstrb", {28'b0, m_axi_wstrb}, 32'hF);
    if (m_axi_arvalid) chk("araddr", m_axi_araddr, BASE + 32'h4);
  endtask

  task automatic track();
    if (!aresetn) begin
      phase = 0; seen = 0;
      prev_aw_hs = 0; prev_aw_wait = 0; prev_w_hs = 0; prev_w_wait = 0; prev_awv = 0; prev_wv = 0;
      return;
    end
    if (cmd_valid && cmd_ready)        phase = 1;
    if (m_axi_rvalid && m_axi_rready)  phase = 2;
    if (res_valid && res_ready)        phase = 0;
    prev_aw_hs   = m_axi_awvalid && m_axi_awready;
    prev_aw_wait = m_axi_awvalid && !m_axi_awready;
    prev_w_hs    = m_axi_wvalid && m_axi_wready;
    prev_w_wait  = m_axi_wvalid && !m_axi_wready;
    prev_awv     = m_axi_awvalid;
    prev_wv      = m_axi_wvalid;
    prev_awaddr  = m_axi_awaddr;
    prev_wdata   = m_axi_wdata;
    seen = 1;
  endtask

  initial forever begin
    @(negedge aclk);
    check_cycle();
    slave_step();
    track();
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic run_cmd(input logic [31:0] pat, input int len, input logic dir,
                         input int awd, input int wd, input int bd, input int errn,
                         input int hold, output logic [31:0] d, output logic e);
    logic [31:0] exp_wr[$];
    logic [3:0]  r;
    logic        b;
    logic        e_err;
    int          eff, idx, n;
    aw_delay = awd; w_delay = wd; b_delay = bd; err_on = errn;
    wr_count = 0; rd_count = 0; wr_log.delete();
    eff = (len > MAXL) ? MAXL : len;
    r = exp_reg; e_err = 0;
    for (int k = 0; k < eff; k++) begin
      idx = dir ? k : eff - 1 - k;
      b = pat[idx];
      exp_wr.push_back({29'b0, dir, b, 1'b1});
      if (errn == k + 1) begin e_err = 1; break; end
      r = dir ? {b, r[3:1]} : {r[2:0], b};
    end
    exp_reg = r; exp_data = {28'b0, r}; exp_err = e_err;
    n = 0;
    while (!cmd_ready && n < 200) begin tick(); n++; end
    chk1("cmd_ready_wait", cmd_ready, 1'b1);
    cmd_valid = 1; cmd_pattern = pat; cmd_len = 6'(len); cmd_dir = dir;
    tick();
    cmd_valid = 0;
    n = 0;
    while (!res_valid && n < 3000) begin tick(); n++; end
    chk1("res_valid_wait", res_valid, 1'b1);
    repeat (hold) tick();
    chk1("res_valid_held", res_valid, 1'b1);
    d = res_data; e = res_err;
    chk("cmd_res_data", d, exp_data);
    chk1("cmd_res_err", e, exp_err);
    res_ready = 1;
    tick();
    res_ready = 0;
    chk("write_count", 32'(wr_log.size()), 32'(exp_wr.size()));
    if (wr_log.size() == exp_wr.size())
      foreach (exp_wr[i]) chk($sformatf("wdata[%0d]", i), wr_log[i], exp_wr[i]);
    chk("read_count", 32'(rd_count), 32'd1);
  endtask

  task automatic chk_lit4(input logic [31:0] a, input logic [31:0] b2, input logic [31:0] c,
                          input logic [31:0] dd);
    logic [31:0] l[4];
    l[0] = a; l[1] = b2; l[2] = c; l[3] = dd;
    chk("lit_write_count", 32'(wr_log.size()), 32'd4);
    if (wr_log.size() == 4)
      for (int i = 0; i < 4; i++) chk($sformatf("lit_wdata[%0d]", i), wr_log[i], l[i]);
  endtask

  initial begin
    logic [31:0] d;
    logic        e;
    int          n;
    #1;
    chk1("rst0_cmd_ready", cmd_ready, 1'b0);
    chk1("rst0_res_valid", res_valid, 1'b0);
    chk("rst0_res_data", res_data, 32'h0);
    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1;

    run_cmd(32'h9, 4, 1'b0, 0, 0, 0, 0, 0, d, e);
    chk_lit4(32'h3, 32'h1, 32'h1, 32'h3);
    chk("lit_res_9", d, 32'h9);
    chk1("lit_err_0", e, 1'b0);

    run_cmd(32'hC, 4, 1'b1, 0, 0, 0, 0, 0, d, e);
    chk_lit4(32'h5, 32'h5, 32'h7, 32'h7);
    chk("lit_res_c", d, 32'hC);

    run_cmd(32'hFFFF_FFFF, 0, 1'b0, 0, 0, 0, 0, 0, d, e);
    chk("lit_len0_writes", 32'(wr_log.size()), 32'd0);
    chk("lit_len0_res", d, 32'hC);

    run_cmd(32'h6, 4, 1'b0, 0, 3, 0, 0, 0, d, e);
    chk("lit_wdelay_res", d, 32'h6);
    run_cmd(32'h3, 4, 1'b1, 3, 0, 1, 0, 0, d, e);
    chk("lit_awdelay_res", d, 32'h3);

    run_cmd(32'hA, 4, 1'b0, 1, 1, 2, 2, 0, d, e);
    chk("lit_err_writes", 32'(wr_log.size()), 32'd2);
    chk1("lit_err_flag", e, 1'b1);
    chk("lit_err_res", d, 32'h7);

    run_cmd(32'h1, 1, 1'b0, 0, 0, 0, 0, 0, d, e);
    chk("lit_len1_res", d, 32'hF);
    run_cmd(32'hA5A5_F00F, 32, 1'b1, 0, 1, 0, 0, 0, d, e);
    chk("lit_len32_res", d, 32'hA);
    run_cmd(32'h8000_0001, 45, 1'b0, 1, 0, 0, 0, 0, d, e);
    chk("lit_clamp_writes", 32'(wr_log.size()), 32'd32);
    chk("lit_clamp_res", d, 32'h1);

    // reset while waiting for a write response
    aw_delay = 0; w_delay = 0; b_delay = 8; err_on = 0; wr_log.delete();
    n = 0;
    while (!cmd_ready && n < 200) begin tick(); n++; end
    cmd_valid = 1; cmd_pattern = 32'hF; cmd_len = 6'd4; cmd_dir = 1'b0;
    tick();
    cmd_valid = 0;
    n = 0;
    while (!m_axi_bready && n < 100) begin tick(); n++; end
    chk1("reach_wresp", m_axi_bready, 1'b1);
    #2 aresetn = 0;
    #1;
    chk1("async_cmd_ready", cmd_ready, 1'b0);
    chk1("async_bready", m_axi_bready, 1'b0);
    chk("async_res_data", res_data, 32'h0);
    chk1("async_res_err", res_err, 1'b0);
    exp_reg = '0;
    tick(); tick();
    aresetn = 1;
    tick();
    chk1("post_rst_cmd_ready", cmd_ready, 1'b1);

    run_cmd(32'h5, 3, 1'b0, 2, 0, 1, 0, 6, d, e);
    chk("lit_hold_res", d, 32'h5);
    run_cmd(32'h0, 0, 1'b1, 0, 0, 0, 0, 2, d, e);
    chk("lit_len0_after_rst", d, 32'h5);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, actual=timeout required=finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axi_shift_sequencer.md
AXI_SHIFT_SEQUENCER -- requirements
Module: axi_shift_sequencer

Interface
REQ-001 Parameter ADDR_BASE, default 32'h0000_0000, base address of the AXI-Lite shift-register slave.
REQ-002 Parameter MAX_LEN, default 32, largest accepted shift count; cmd_len is 6 bits.
REQ-003 Port aclk, input, 1, single clock; all logic rising-edge.
REQ-004 Port aresetn, input, 1, asynchronous active-low reset.
REQ-005 Port cmd_valid/cmd_ready, input/output, 1/1, command handshake.
REQ-006 Port cmd_pattern, input, 32, bits to shift in.
REQ-007 Port cmd_len, input, 6, number of shifts, 0..MAX_LEN.
REQ-008 Port cmd_dir, input, 1, 0 = shift left, 1 = shift right.
REQ-009 Port res_valid/res_ready, output/input, 1/1, result handshake.
REQ-010 Port res_data, output, 32, readback of slave offset 0x04.
REQ-011 Port res_err, output, 1, any non-OKAY BRESP or RRESP seen.
REQ-012 Ports m_axi_awaddr[31:0], awvalid, awready, wdata[31:0], wstrb[3:0], wvalid, wready, bresp[1:0], bvalid, bready, araddr[31:0], arvalid, arready, rdata[31:0], rresp[1:0], rvalid, rready: AXI4-Lite master, standard directions.

Function
REQ-013 FSM states: IDLE, WRITE, WRESP, READ, RRESP, DONE.
REQ-014 IDLE: cmd_ready=1; on cmd_valid, latch pattern/len/dir, clear bit counter and error, go WRITE, or READ if cmd_len=0.
REQ-015 cmd_ready SHALL be 1 only in IDLE.
REQ-016 Each shift is one write to ADDR_BASE+0x00 with wdata = {29'b0, DIR, DIN, 1'b1}, wstrb = 4'hF.
REQ-017 Bit order: dir=0 sends pattern[len-1] down to pattern[0]; dir=1 sends pattern[0] up to pattern[len-1].
REQ-018 WRITE: awvalid and wvalid assert together on entry; each deasserts the cycle after its own ready handshake; address/data stable while valid; go WRESP when both handshakes are complete, in either order or the same cycle.
REQ-019 WRESP: bready=1; on bvalid, increment counter; bresp!=0 sets error and goes READ (remaining bits skipped); else go WRITE if counter<len, else READ.
REQ-020 READ: araddr = ADDR_BASE+0x04, arvalid held until arready; go RRESP.
REQ-021 RRESP: rready=1; on rvalid, latch rdata into res_data, OR (rresp!=0) into error; go DONE.
REQ-022 DONE: res_valid=1, res_data/res_err stable until res_ready; then IDLE.
REQ-023 cmd_len > MAX_LEN is clamped to MAX_LEN.
REQ-024 No outstanding transactions: at most one AXI transaction in flight at any time.
REQ-025 bready SHALL be 1 only in WRESP; rready only in RRESP; all other master valids 0 outside their states.

Reset
REQ-026 aresetn low SHALL immediately force IDLE and drive cmd_ready=0 during reset, then 1 after release.
REQ-027 Reset values: all m_axi valid/ready outputs 0, addresses/wdata/wstrb 0, res_valid 0, res_data 0, res_err 0, counter 0.
REQ-028 Reset mid-transaction abandons the transaction; no recovery is attempted.

Structure
REQ-029 Shared package holds the FSM state enum, CTRL_OFFSET=0x00, DATA_OFFSET=0x04, control bit positions EN=0, DIN=1, DIR=2, and RESP_OKAY=2'b00.
REQ-030 Single module; no sub-modules.

Verification (bench pairs the block with an AXI-Lite slave model containing a 4-bit shift register)
REQ-031 cmd pattern=4'b1001, len=4, dir=0 -> wdata sequence 3,1,1,3 to 0x00; res_data=4'h9, res_err=0.
REQ-032 Then pattern=4'b1100, len=4, dir=1 -> wdata 5,5,7,7; res_data=4'hC.
REQ-033 len=0 -> no writes, one read of 0x04, res_valid with current register value.
REQ-034 Slave delays wready 3 cycles after awready, and separately the reverse -> exactly one write per bit, awvalid/wvalid each drop one cycle after their own handshake.
REQ-035 Slave returns bresp=2'b10 on 2nd write of len=4 -> no 3rd write, read issued, res_err=1.
REQ-036 aresetn pulsed low during WRESP, res_ready held low in DONE -> outputs reset values immediately; res_valid holds until res_ready.
